// File: rtl/apple2_bus_master.sv
// apple2_bus_master: initiator side of the Apple II slot bus, intended as a host
// emulator in FPGA fixtures and benches for slot cards.
//
// It derives PHI1/PHI0 from C7M and runs one bus cycle every 7 C7M periods
// (T0..T6). It also drives A, R/W, write data and the slot selects, and it
// samples read data.
//
// Optional build macro: APPLE2_LONG_CYCLE_EN. When it is defined, every 65th
// bus cycle gets an extra T7 state with PHI0 held high.
//
// Ports
//   C7M        in   7M clock; all state changes on its rising edge
//   RES        in   synchronous active-high reset
//   req        in   transaction request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   16-bit 6502 address
//   req_wdata  in   write data
//   ack        out  one-C7M pulse in the T0 after the transaction cycle
//   rdata      out  read data, updated with ack and held until the next read ack
//   PHI1/PHI0  out  bus phase clocks (PHI1 high T0..T2, PHI0 high T3..end)
//   A, nWE     out  address and R/W (low = write), stable for a whole cycle
//   D          io   data bus, driven only from T4 of a write cycle
//   nDEVSEL    out  $C080+SLOT*16..+15
//   nIOSEL     out  $Cs00..$CsFF
//   nIOSTRB    out  $C800..$CFFF
//   nRES       out  card reset, low for RES_CYCLES bus cycles after RES
//
// req is sampled at every end-of-cycle edge while nRES is high. A request that
// is still high at that edge starts another transaction with the values then
// on req_*. Back-to-back streams work this way. A requester that wants a single
// transaction drops req once its own cycle has begun.
module apple2_bus_master #(
   parameter int unsigned SLOT       = 7,
   parameter logic [15:0] PARK_ADDR  = 16'hFFFC,
   parameter int unsigned RES_CYCLES = 8
) (
   input  logic        C7M,
   input  logic        RES,
   input  logic        req,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        ack,
   output logic [7:0]  rdata,
   output logic        PHI1,
   output logic        PHI0,
   output logic [15:0] A,
   output logic        nWE,
   inout  wire  [7:0]  D,
   output logic        nDEVSEL,
   output logic        nIOSEL,
   output logic        nIOSTRB,
   output logic        nRES
);

   localparam logic [2:0]  SlotNum = SLOT[2:0];
   localparam int unsigned ResCntW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
   localparam logic [ResCntW-1:0] ResLast = ResCntW'(RES_CYCLES - 1);

   typedef enum logic [2:0] {
      StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7
   } tstate_e;

   tstate_e            t_q, t_d;
   logic               phi1_q, phi1_d;
   logic               phi0_q, phi0_d;
   logic [15:0]        a_q, a_d;
   logic               nwe_q, nwe_d;
   logic [7:0]         wdata_q, wdata_d;
   logic               txn_q, txn_d;      // current bus cycle carries a transaction
   logic [2:0]         sel_n_q, sel_n_d;  // {nDEVSEL, nIOSEL, nIOSTRB}
   logic               d_oe_q, d_oe_d;
   logic               ack_q, ack_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               nres_q, nres_d;
   logic [ResCntW-1:0] res_cnt_q, res_cnt_d;

   logic last_t;   // current state is the final T of this bus cycle
   logic accept;
   logic dev_hit, io_hit, strb_hit;

`ifdef APPLE2_LONG_CYCLE_EN
   logic [6:0] lc_cnt_q, lc_cnt_d;
   logic       long_cyc;

   assign long_cyc = (lc_cnt_q == 7'd64);
   assign last_t   = long_cyc ? (t_q == StT7) : (t_q == StT6);

   always_comb begin
      lc_cnt_d = lc_cnt_q;
      if (last_t) begin
         lc_cnt_d = long_cyc ? 7'd0 : lc_cnt_q + 7'd1;
      end
   end

   always_ff @(posedge C7M) begin
      if (RES) begin
         lc_cnt_q <= 7'd0;
      end else begin
         lc_cnt_q <= lc_cnt_d;
      end
   end
`else
   assign last_t = (t_q == StT6);
`endif

   assign accept = req & nres_q;

   // Decode works on the registered address, so the selects follow the address
   // that is actually on the bus.
   assign dev_hit  = (a_q[15:4] == {8'hC0, 1'b1, SlotNum});
   assign io_hit   = (a_q[15:8] == {5'b11000, SlotNum});
   assign strb_hit = (a_q[15:11] == 5'b11001);

   // Bus cycle sequencer
   always_comb begin
      t_d = t_q;
      case (t_q)
         StT0:    t_d = StT1;
         StT1:    t_d = StT2;
         StT2:    t_d = StT3;
         StT3:    t_d = StT4;
         StT4:    t_d = StT5;
         StT5:    t_d = StT6;
         StT6:    t_d = last_t ? StT0 : StT7;
         StT7:    t_d = StT0;
         default: t_d = StT0;
      endcase
   end

   always_comb begin
      phi1_d    = (t_d == StT0) || (t_d == StT1) || (t_d == StT2);
      phi0_d    = ~phi1_d;
      a_d       = a_q;
      nwe_d     = nwe_q;
      wdata_d   = wdata_q;
      txn_d     = txn_q;
      sel_n_d   = sel_n_q;
      d_oe_d    = d_oe_q;
      ack_d     = 1'b0;
      rdata_d   = rdata_q;
      nres_d    = nres_q;
      res_cnt_d = res_cnt_q;

      if (last_t) begin
         // This edge ends the cycle: it launches the next cycle and retires the
         // current one.
         a_d     = accept ? req_addr : PARK_ADDR;
         nwe_d   = ~(accept & req_we);
         wdata_d = accept ? req_wdata : wdata_q;
         txn_d   = accept;
         sel_n_d = 3'b111;
         d_oe_d  = 1'b0;
         ack_d   = txn_q;
         if (txn_q && nwe_q) begin
            rdata_d = D;
         end
         if (!nres_q) begin
            if (res_cnt_q == ResLast) begin
               nres_d = 1'b1;
            end else begin
               res_cnt_d = res_cnt_q + ResCntW'(1);
            end
         end
      end else if (t_q == StT2) begin
         sel_n_d = {~dev_hit, ~io_hit, ~strb_hit};
      end else if (t_q == StT3) begin
         d_oe_d = txn_q & ~nwe_q;
      end
   end

   always_ff @(posedge C7M) begin
      if (RES) begin
         t_q       <= StT0;
         phi1_q    <= 1'b1;
         phi0_q    <= 1'b0;
         a_q       <= PARK_ADDR;
         nwe_q     <= 1'b1;
         wdata_q   <= 8'h00;
         txn_q     <= 1'b0;
         sel_n_q   <= 3'b111;
         d_oe_q    <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= 8'h00;
         nres_q    <= 1'b0;
         res_cnt_q <= '0;
      end else begin
         t_q       <= t_d;
         phi1_q    <= phi1_d;
         phi0_q    <= phi0_d;
         a_q       <= a_d;
         nwe_q     <= nwe_d;
         wdata_q   <= wdata_d;
         txn_q     <= txn_d;
         sel_n_q   <= sel_n_d;
         d_oe_q    <= d_oe_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
         nres_q    <= nres_d;
         res_cnt_q <= res_cnt_d;
      end
   end

   assign PHI1    = phi1_q;
   assign PHI0    = phi0_q;
   assign A       = a_q;
   assign nWE     = nwe_q;
   assign D       = d_oe_q ? wdata_q : 'z;
   assign nDEVSEL = sel_n_q[2];
   assign nIOSEL  = sel_n_q[1];
   assign nIOSTRB = sel_n_q[0];
   assign ack     = ack_q;
   assign rdata   = rdata_q;
   assign nRES    = nres_q;

endmodule

// File: tb/tb_apple2_bus_master.sv
// tb_apple2_bus_master: directed, table-driven bench for apple2_bus_master.
// A small cycle model (m_t/m_cyc) tracks bus timing for alignment only. All
// expected values come from the vector table and from hand-written sequences.
// A bench-side card drives D whenever the master must not drive it. Any
// unexpected master drive then corrupts the value read back.
module tb_apple2_bus_master;

`ifdef APPLE2_LONG_CYCLE_EN
   localparam bit LongEn = 1'b1;
`else
   localparam bit LongEn = 1'b0;
`endif
   localparam logic [15:0] Park = 16'hFFFC;

   logic        C7M = 1'b0;
   logic        RES = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [7:0]  req_wdata = 8'h00;
   wire         ack, PHI1, PHI0, nWE, nDEVSEL, nIOSEL, nIOSTRB, nRES;
   wire  [7:0]  rdata;
   wire  [15:0] A;
   wire  [7:0]  D;
   logic        card_oe = 1'b1;
   logic [7:0]  card_data = 8'h00;

   int checks = 0;
   int failures = 0;

   assign D = card_oe ? card_data : 'z;

   apple2_bus_master #(.SLOT(7), .PARK_ADDR(Park), .RES_CYCLES(8)) dut (
      .C7M(C7M), .RES(RES), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .PHI1(PHI1), .PHI0(PHI0),
      .A(A), .nWE(nWE), .D(D), .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL),
      .nIOSTRB(nIOSTRB), .nRES(nRES)
   );

   always #5 C7M = ~C7M;

   // Bus timing model used for alignment
   int m_t = 0;
   int m_cyc = 0;
   int m_last;
   always_comb m_last = (LongEn && m_cyc == 64) ? 7 : 6;
   always @(posedge C7M) begin
      if (RES) begin
         m_t <= 0;
         m_cyc <= 0;
      end else if (m_t == m_last) begin
         m_t <= 0;
         m_cyc <= (m_cyc == 64) ? 0 : m_cyc + 1;
      end else begin
         m_t <= m_t + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  card;
      logic [7:0]  rdata;
      logic [2:0]  sel;   // expected {nDEVSEL, nIOSEL, nIOSTRB} during T3..T6
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stop at a negedge in T<n> of a normal-length cycle whose successor is also normal
   task automatic wait_t(input int n);
      int k;
      k = 0;
      @(negedge C7M);
      while (!(m_t == n && (!LongEn || (m_cyc != 63 && m_cyc != 64))) && k < 1000) begin
         @(negedge C7M);
         k++;
      end
      if (k >= 1000) begin
         checks++;
         failures++;
         $display("FAIL align: got timeout expected T%0d", n);
      end
   endtask

   task automatic run_txn(input vec_t v);
      wait_t(6);
      req = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      card_oe = 1'b1; card_data = v.we ? 8'h00 : v.card;
      for (int t = 0; t < 7; t++) begin
         @(negedge C7M);
         if (t == 0) req = 1'b0;
         check("A", A, v.addr);
         check("nWE", nWE, !v.we);
         check("PHI1", PHI1, t <= 2);
         check("PHI0", PHI0, t >= 3);
         check("sel", {nDEVSEL, nIOSEL, nIOSTRB}, (t >= 3) ? v.sel : 3'b111);
         check("D", D, (v.we && t >= 4) ? v.wdata : card_data);
         check("ack_idle", ack, 0);
         if (v.we && t == 3) card_oe = 1'b0;
      end
      @(negedge C7M);
      card_oe = 1'b1; card_data = 8'h00;
      check("ack_pulse", ack, 1);
      check("rdata", rdata, v.rdata);
      check("ack_T0_PHI1", PHI1, 1);
      @(negedge C7M);
      check("ack_low", ack, 0);
   endtask

   initial begin
      int acks, ack1, ack2, gap, bad_a;
      logic [7:0] rd1, rd2;

      vecs[0]  = '{1'b0, 16'hC0F3, 8'h00, 8'hA5, 8'hA5, 3'b011};
      vecs[1]  = '{1'b1, 16'hC700, 8'h3C, 8'h00, 8'hA5, 3'b101};
      vecs[2]  = '{1'b0, 16'hC0E3, 8'h00, 8'h77, 8'h77, 3'b111};
      vecs[3]  = '{1'b0, 16'hC800, 8'h00, 8'h11, 8'h11, 3'b110};
      vecs[4]  = '{1'b0, 16'hCFFF, 8'h00, 8'h22, 8'h22, 3'b110};
      vecs[5]  = '{1'b1, 16'hC0F0, 8'h55, 8'h00, 8'h22, 3'b011};
      vecs[6]  = '{1'b0, 16'hC7FF, 8'h00, 8'h3E, 8'h3E, 3'b101};
      vecs[7]  = '{1'b0, 16'hC000, 8'h00, 8'h44, 8'h44, 3'b111};
      vecs[8]  = '{1'b0, 16'hC600, 8'h00, 8'h66, 8'h66, 3'b111};
      vecs[9]  = '{1'b1, 16'hCA5A, 8'h0F, 8'h00, 8'h66, 3'b110};
      vecs[10] = '{1'b0, 16'hC07F, 8'h00, 8'h12, 8'h12, 3'b111};
      vecs[11] = '{1'b0, 16'hC100, 8'h00, 8'h9C, 8'h9C, 3'b111};

      // Reset values, nRES release timing, req ignored while nRES=0
      repeat (3) @(negedge C7M);
      check("rst_PHI1", PHI1, 1);
      check("rst_PHI0", PHI0, 0);
      check("rst_A", A, Park);
      check("rst_nWE", nWE, 1);
      check("rst_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_nRES", nRES, 0);
      check("rst_D", D, 8'h00);
      RES = 1'b0;
      req = 1'b1; req_we = 1'b0; req_addr = 16'hC0F3;
      acks = 0;
      for (int e = 1; e <= 70; e++) begin
         @(negedge C7M);
         if (ack) acks++;
         if (e == 1) check("nRES_e1", nRES, 0);
         if (e == 55) check("nRES_e55", nRES, 0);
         if (e == 56) begin
            check("nRES_e56", nRES, 1);
            req = 1'b0;
         end
      end
      check("no_ack_in_nRES", acks, 0);

      // Table-driven single transactions
      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // Back-to-back reads $CFFF then $C800
      wait_t(6);
      req = 1'b1; req_we = 1'b0; req_addr = 16'hCFFF; card_data = 8'h81;
      acks = 0; ack1 = 0; ack2 = 0; gap = 7; rd1 = 8'h00; rd2 = 8'h00;
      for (int n = 1; n <= 20; n++) begin
         @(negedge C7M);
         if (n == 1) req_addr = 16'hC800;
         if (n == 8) begin
            req = 1'b0;
            card_data = 8'h82;
            gap = m_last + 1;
         end
         if (ack) begin
            acks++;
            if (acks == 1) begin ack1 = n; rd1 = rdata; end
            else begin ack2 = n; rd2 = rdata; end
         end
         if (n >= 4 && n <= 7) check("b2b_strb1", nIOSTRB, 0);
         if (n >= 11 && n <= 14) check("b2b_strb2", nIOSTRB, 0);
         if (n == 3) check("b2b_A1", A, 16'hCFFF);
         if (n == 10) check("b2b_A2", A, 16'hC800);
      end
      card_data = 8'h00;
      check("b2b_acks", acks, 2);
      check("b2b_ack1_at", ack1, 8);
      check("b2b_gap", ack2 - ack1, gap);
      check("b2b_rd1", rd1, 8'h81);
      check("b2b_rd2", rd2, 8'h82);

      // req dropped before acceptance
      wait_t(2);
      req = 1'b1; req_we = 1'b1; req_addr = 16'hC0F3; req_wdata = 8'hEE;
      repeat (3) @(negedge C7M);
      req = 1'b0;
      acks = 0; bad_a = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge C7M);
         if (ack) acks++;
         if (A != Park) bad_a++;
      end
      check("drop_no_ack", acks, 0);
      check("drop_A_parked", bad_a, 0);

`ifdef APPLE2_LONG_CYCLE_EN
      begin
         int k, len, cyc, n_long, first_long, second_long;
         logic phi_prev;
         k = 0;
         @(negedge C7M);
         while (!(m_cyc == 63 && m_t == 6) && k < 1000) begin
            @(negedge C7M);
            k++;
         end
         check("long_align", k < 1000, 1);
         req = 1'b1; req_we = 1'b0; req_addr = 16'hC0F3; card_data = 8'h5C;
         for (int n = 1; n <= 8; n++) begin
            @(negedge C7M);
            if (n == 1) req = 1'b0;
            if (n == 8) begin
               check("long_T7_PHI0", PHI0, 1);
               check("long_T7_ack", ack, 0);
               card_data = 8'hC5;
            end
         end
         @(negedge C7M);
         card_data = 8'h00;
         check("long_ack", ack, 1);
         check("long_rdata", rdata, 8'hC5);
         phi_prev = PHI1; len = 1; cyc = 0; n_long = 0; first_long = -1; second_long = -1;
         for (int n = 0; n < 1200 && cyc < 130; n++) begin
            @(negedge C7M);
            if (PHI1 && !phi_prev) begin
               if (len == 8) begin
                  n_long++;
                  if (first_long < 0) first_long = cyc; else second_long = cyc;
               end
               cyc++;
               len = 1;
            end else begin
               len++;
            end
            phi_prev = PHI1;
         end
         check("long_count", n_long, 2);
         check("long_first", first_long, 64);
         check("long_spacing", second_long - first_long, 65);
      end
`endif

      // Reset at T4 of a write
      wait_t(6);
      req = 1'b1; req_we = 1'b1; req_addr = 16'hC700; req_wdata = 8'h3C;
      for (int n = 1; n <= 5; n++) begin
         @(negedge C7M);
         if (n == 1) req = 1'b0;
         if (n == 4) card_oe = 1'b0;
      end
      check("abort_D_driven", D, 8'h3C);
      RES = 1'b1; card_oe = 1'b1; card_data = 8'h00;
      @(negedge C7M);
      check("abort_nWE", nWE, 1);
      check("abort_D", D, 8'h00);
      check("abort_A", A, Park);
      check("abort_sel", {nDEVSEL, nIOSEL, nIOSTRB}, 3'b111);
      check("abort_PHI1", PHI1, 1);
      check("abort_ack", ack, 0);
      RES = 1'b0;
      acks = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge C7M);
         if (ack) acks++;
      end
      check("abort_no_ack", acks, 0);
      check("abort_nRES", nRES, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
